image_pixel_op: RTL and testbench
=================================

# image_pixel_op

Parametrised AXI4-Stream pixel-processing stage for the DMA image path: sits between the MM2S stream and the S2MM stream and applies a per-pixel operation to every lane of each beat. Selectable modes are passthrough, invert, saturating brightness offset and binary threshold. Configuration is frame-coherent, so it changes only at frame boundaries. A registered output stage plus a skid buffer give full throughput with registered ready, honour backpressure without dropping beats, and propagate `tlast`; completed frames are counted.

## Interface
- `DWIDTH`, 32: stream data width; must be a multiple of `PWIDTH`.
- `PWIDTH`, 8: pixel (lane) width; lane count `LANES = DWIDTH/PWIDTH`.
- `i_clk` input 1: single clock; all logic on its rising edge.
- `i_arst_n` input 1: asynchronous, active-low reset.
- `i_mode` input 2: 00 passthrough, 01 invert, 10 offset, 11 threshold.
- `i_offset` input PWIDTH: signed two's-complement brightness offset (mode 10).
- `i_thresh` input PWIDTH: unsigned threshold (mode 11).
- `s_axis_data` input DWIDTH: input beat; lane k = bits [k*PWIDTH +: PWIDTH].
- `s_axis_valid` input 1: input beat valid.
- `s_axis_last` input 1: last beat of frame.
- `s_axis_ready` output 1: registered ready.
- `m_axis_data` output DWIDTH: processed beat.
- `m_axis_valid` output 1: output beat valid.
- `m_axis_last` output 1: `tlast` carried with the beat.
- `m_axis_ready` input 1: downstream ready.
- `o_frame_cnt` output 16: completed output frames, wraps.

## Operation
- Per-lane function, with `MAX = 2^PWIDTH-1`:
  - mode 00: p.
  - mode 01: MAX-p.
  - mode 10: p + sign-extended offset, computed at PWIDTH+2 bits, clamped to [0, MAX].
  - mode 11: MAX if p >= thresh, else 0.
- Frame-coherent configuration:
  - Flag `sof` resets to 1. After an accepted beat it is set to 1 if the beat had last=1, and cleared to 0 if last=0.
  - On an accepted beat with sof=1, shadow {mode, offset, thresh} <= inputs, and that beat uses the inputs directly.
  - All other beats use the shadow.
  - Config changes mid-frame have no effect until the next frame's first beat.
- Buffering: one output register (data/last/valid) plus one skid register (data/last/valid). The processed value is computed from `s_axis_data` before registering.
- `s_axis_ready` = registered NOT(skid valid after this cycle).
- Accepted input (valid & ready):
  - If the output register is empty, or m_axis_ready=1 this cycle, the beat loads the output register.
  - Otherwise the beat loads the skid register.
- Output transfer (m_axis_valid & m_axis_ready):
  - If the skid is valid, the output loads from the skid and the skid clears.
  - Else, if there is no new input, m_axis_valid clears.
- No beat is ever dropped or duplicated, and order is preserved. Data and last are held stable while m_axis_valid=1 and m_axis_ready=0.
- `o_frame_cnt` increments by 1 on each output transfer with m_axis_last=1, wrapping 0xFFFF -> 0x0000.

## Timing
- Reset (asynchronous assert):
  - s_axis_ready=0, m_axis_valid=0, m_axis_data=0, m_axis_last=0, o_frame_cnt=0.
  - Skid empty, sof=1, shadow=0.
  - s_axis_ready rises on the first clock edge after reset release.
- Latency: input beat accepted at edge N appears on m_axis at edge N (registered), i.e. visible in cycle N+1.
- Throughput: 1 beat/cycle while m_axis_ready=1.
- Backpressure:
  - With m_axis_ready held 0, at most 2 beats are absorbed (output + skid).
  - s_axis_ready drops the cycle after the skid fills.
  - s_axis_ready reasserts the cycle after the first output transfer empties the skid.
- Simultaneous input accept and output transfer with the skid empty: the output register reloads with the new beat and m_axis_valid stays 1.
- Reset mid-frame discards all buffered beats; the next accepted beat is treated as a frame start.
- Input valid must not depend on ready, and output valid does not depend on m_axis_ready.

## Test plan
- Mode 01, DWIDTH=32, beat 0x00FF_7F10 -> 0xFF00_80EF one cycle later; a 4-beat frame with last on beat 4 -> m_axis_last on beat 4 only, and o_frame_cnt 0 -> 1.
- Mode 10, offset 0x14 (+20) on lanes 0xF0/0x05 -> 0xFF/0x19; offset 0xEC (-20) on 0x0A/0x80 -> 0x00/0x6C.
- Mode 11, thresh 0x80, lanes 0x7F/0x80/0xFF/0x00 -> 0x00/0xFF/0xFF/0x00.
- Switch i_mode 01->00 on beat 2 of a 3-beat frame -> all 3 beats inverted; the next frame's beats pass through unchanged.
- Random valid/ready backpressure over 1000 beats -> output sequence equals the reference model, no loss or duplication; s_axis_ready goes low only after 2 beats are buffered.
- Assert reset with 2 beats buffered -> all outputs take their reset values immediately, no buffered beat emitted, o_frame_cnt=0; the 65536th frame end wraps o_frame_cnt to 0.

Source files
------------

// File: rtl/image_pixel_op.sv
// AXI4-Stream per-pixel operation stage: passthrough / invert / saturating offset / threshold
// applied to every lane, with frame-coherent configuration, a registered output and a skid buffer.
module image_pixel_op #(
  parameter int DWIDTH = 32,
  parameter int PWIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic [1:0]        i_mode,
  input  logic [PWIDTH-1:0] i_offset,
  input  logic [PWIDTH-1:0] i_thresh,
  input  logic [DWIDTH-1:0] s_axis_data,
  input  logic              s_axis_valid,
  input  logic              s_axis_last,
  output logic              s_axis_ready,
  output logic [DWIDTH-1:0] m_axis_data,
  output logic              m_axis_valid,
  output logic              m_axis_last,
  input  logic              m_axis_ready,
  output logic [15:0]       o_frame_cnt
);

  localparam int LANES = DWIDTH / PWIDTH;
  localparam logic [PWIDTH-1:0] MAX = '1;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_INV    = 2'b01,
    MODE_OFFSET = 2'b10,
    MODE_THRESH = 2'b11
  } mode_e;

  function automatic logic [PWIDTH-1:0] pixel_op(input logic [1:0]        mode,
                                                 input logic [PWIDTH-1:0] p,
                                                 input logic [PWIDTH-1:0] off,
                                                 input logic [PWIDTH-1:0] thr);
    logic [PWIDTH+1:0] sum;
    logic [PWIDTH-1:0] res;
    // Two guard bits: bit PWIDTH+1 flags underflow, bit PWIDTH flags overflow.
    sum = {2'b00, p} + {{2{off[PWIDTH-1]}}, off};
    case (mode_e'(mode))
      MODE_PASS:   res = p;
      MODE_INV:    res = MAX - p;
      MODE_OFFSET: begin
        if (sum[PWIDTH+1])   res = '0;
        else if (sum[PWIDTH]) res = MAX;
        else                  res = sum[PWIDTH-1:0];
      end
      default:     res = (p >= thr) ? MAX : '0;
    endcase
    return res;
  endfunction

  logic              r_sof;
  logic [1:0]        r_mode;
  logic [PWIDTH-1:0] r_offset;
  logic [PWIDTH-1:0] r_thresh;

  logic [DWIDTH-1:0] r_out_data;
  logic              r_out_last;
  logic              r_out_valid;
  logic [DWIDTH-1:0] r_skid_data;
  logic              r_skid_last;
  logic              r_skid_valid;
  logic              r_s_ready;
  logic [15:0]       r_frame_cnt;

  logic [1:0]        w_mode;
  logic [PWIDTH-1:0] w_offset;
  logic [PWIDTH-1:0] w_thresh;
  logic [DWIDTH-1:0] w_proc;
  logic              w_in_acc;
  logic              w_out_xfer;
  logic              w_load_out;
  logic              w_load_skid;
  logic              w_skid_valid_nxt;

  // The first beat of a frame sees the live inputs; the rest of the frame sees the snapshot.
  assign w_mode   = r_sof ? i_mode   : r_mode;
  assign w_offset = r_sof ? i_offset : r_offset;
  assign w_thresh = r_sof ? i_thresh : r_thresh;

  always_comb begin
    // NOTE: default assignment first so no path leaves w_proc unassigned (no latch).
    w_proc = '0;
    for (int k = 0; k < LANES; k++) begin
      w_proc[k*PWIDTH +: PWIDTH] = pixel_op(w_mode, s_axis_data[k*PWIDTH +: PWIDTH],
                                            w_offset, w_thresh);
    end
  end

  assign w_in_acc    = s_axis_valid & r_s_ready;
  assign w_out_xfer  = r_out_valid & m_axis_ready;
  assign w_load_out  = w_in_acc & (~r_out_valid | m_axis_ready);
  assign w_load_skid = w_in_acc & ~w_load_out;
  // Ready is low whenever the skid is full, so a skid drain never races a new input.
  assign w_skid_valid_nxt = r_skid_valid ? ~w_out_xfer : w_load_skid;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_sof        <= 1'b1;
      r_mode       <= '0;
      r_offset     <= '0;
      r_thresh     <= '0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_skid_data  <= '0;
      r_skid_last  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_s_ready    <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_s_ready    <= ~w_skid_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;

      if (w_out_xfer && r_skid_valid) begin
        r_out_data <= r_skid_data;
        r_out_last <= r_skid_last;
      end else if (w_load_out) begin
        r_out_data  <= w_proc;
        r_out_last  <= s_axis_last;
        r_out_valid <= 1'b1;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end

      if (w_load_skid) begin
        r_skid_data <= w_proc;
        r_skid_last <= s_axis_last;
      end

      if (w_in_acc) begin
        r_sof <= s_axis_last;
        if (r_sof) begin
          r_mode   <= i_mode;
          r_offset <= i_offset;
          r_thresh <= i_thresh;
        end
      end

      if (w_out_xfer && r_out_last) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign s_axis_ready = r_s_ready;
  assign m_axis_data  = r_out_data;
  assign m_axis_valid = r_out_valid;
  assign m_axis_last  = r_out_last;
  assign o_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_image_pixel_op.sv
// Self-checking bench for image_pixel_op: directed cases plus random valid/ready traffic
// compared against a frame-level arithmetic reference model and an expected-beat queue.
module tb_image_pixel_op;

  localparam int DW    = 32;
  localparam int PW    = 8;
  localparam int LANES = DW / PW;

  logic          i_clk = 1'b0;
  logic          i_arst_n = 1'b0;
  logic [1:0]    i_mode = '0;
  logic [PW-1:0] i_offset = '0;
  logic [PW-1:0] i_thresh = '0;
  logic [DW-1:0] s_axis_data = '0;
  logic          s_axis_valid = 1'b0;
  logic          s_axis_last = 1'b0;
  logic          s_axis_ready;
  logic [DW-1:0] m_axis_data;
  logic          m_axis_valid;
  logic          m_axis_last;
  logic          m_axis_ready = 1'b0;
  logic [15:0]   o_frame_cnt;

  image_pixel_op #(.DWIDTH(DW), .PWIDTH(PW)) dut (
    .i_clk        (i_clk),
    .i_arst_n     (i_arst_n),
    .i_mode       (i_mode),
    .i_offset     (i_offset),
    .i_thresh     (i_thresh),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_last  (s_axis_last),
    .s_axis_ready (s_axis_ready),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_last  (m_axis_last),
    .m_axis_ready (m_axis_ready),
    .o_frame_cnt  (o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t       exp_q[$];
  logic        m_sof = 1'b1;
  int          m_mode = 0;
  int          m_off = 0;
  int          m_thr = 0;
  logic [15:0] exp_frames = '0;
  logic        ready_live = 1'b0;
  logic        last_acc = 1'b0;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_pixel(input int mode, input int p, input int off, input int thr);
    int v;
    case (mode)
      0:       v = p;
      1:       v = 255 - p;
      2: begin
        v = p + off;
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
      end
      default: v = (p >= thr) ? 255 : 0;
    endcase
    return v;
  endfunction

  function automatic logic [DW-1:0] ref_beat(input int mode, input int off, input int thr,
                                            input logic [DW-1:0] din);
    logic [DW-1:0] r;
    int p;
    int v;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      p = int'(din[k*PW +: PW]);
      v = ref_pixel(mode, p, off, thr);
      r[k*PW +: PW] = v[PW-1:0];
    end
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_sof      = 1'b1;
    exp_frames = '0;
    ready_live = 1'b0;
    last_acc   = 1'b0;
  endtask

  // One clock: check handshake state against the model, update it, then advance past the edge.
  task automatic cycle();
    logic  acc;
    logic  xfer;
    beat_t b;
    if (ready_live) check("s_ready_vs_fill", 64'(s_axis_ready), 64'(exp_q.size() != 2));
    check("m_valid_vs_fill", 64'(m_axis_valid), 64'(exp_q.size() != 0));
    check("frame_cnt", 64'(o_frame_cnt), 64'(exp_frames));
    acc  = s_axis_valid && s_axis_ready;
    xfer = m_axis_valid && m_axis_ready;
    if (xfer && exp_q.size() > 0) begin
      check("out_data", 64'(m_axis_data), 64'(exp_q[0].data));
      check("out_last", 64'(m_axis_last), 64'(exp_q[0].last));
      if (exp_q[0].last) exp_frames = exp_frames + 16'd1;
      void'(exp_q.pop_front());
    end
    if (acc) begin
      if (m_sof) begin
        m_mode = int'(i_mode);
        m_off  = int'(i_offset);
        if (m_off > 127) m_off = m_off - 256;
        m_thr  = int'(i_thresh);
      end
      b.data = ref_beat(m_mode, m_off, m_thr, s_axis_data);
      b.last = s_axis_last;
      exp_q.push_back(b);
      m_sof = s_axis_last;
    end
    last_acc = acc;
    @(posedge i_clk);
    #1;
    ready_live = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    s_axis_valid = 1'b1;
    s_axis_data  = d;
    s_axis_last  = l;
    cycle();
    check("accepted", 64'(last_acc), 64'(1));
  endtask

  initial begin
    int beats;
    int acc_cnt;

    // Reset values.
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_s_ready", 64'(s_axis_ready), 64'(0));
    check("rst_m_valid", 64'(m_axis_valid), 64'(0));
    check("rst_m_data",  64'(m_axis_data),  64'(0));
    check("rst_m_last",  64'(m_axis_last),  64'(0));
    check("rst_frames",  64'(o_frame_cnt),  64'(0));
    i_arst_n = 1'b1;
    #1;
    check("ready_before_edge", 64'(s_axis_ready), 64'(0));
    @(posedge i_clk);
    #1;
    check("ready_after_edge", 64'(s_axis_ready), 64'(1));
    ready_live = 1'b1;

    // Invert, 4-beat frame.
    m_axis_ready = 1'b1;
    i_mode = 2'b01;
    send(32'h00FF_7F10, 1'b0);
    check("inv_beat0", 64'(m_axis_data), 64'h0000_0000_FF00_80EF);
    check("inv_last0", 64'(m_axis_last), 64'(0));
    send(32'h1234_5678, 1'b0);
    check("inv_last1", 64'(m_axis_last), 64'(0));
    send(32'hDEAD_BEEF, 1'b0);
    check("inv_last2", 64'(m_axis_last), 64'(0));
    send(32'h0000_0001, 1'b1);
    check("inv_last3", 64'(m_axis_last), 64'(1));
    s_axis_valid = 1'b0;
    cycle();
    check("frames_after_f1", 64'(o_frame_cnt), 64'(1));

    // Saturating offset, positive and negative.
    i_mode = 2'b10;
    i_offset = 8'h14;
    send(32'h0000_05F0, 1'b1);
    check("offset_pos", 64'(m_axis_data), 64'h0000_0000_1414_19FF);
    i_offset = 8'hEC;
    send(32'h0000_800A, 1'b1);
    check("offset_neg", 64'(m_axis_data), 64'h0000_0000_0000_6C00);

    // Threshold.
    i_mode = 2'b11;
    i_thresh = 8'h80;
    send(32'h00FF_807F, 1'b1);
    check("thresh", 64'(m_axis_data), 64'h0000_0000_00FF_FF00);

    // Mid-frame mode change is ignored until the next frame.
    i_mode = 2'b01;
    send(32'h1234_5678, 1'b0);
    check("coh_b0", 64'(m_axis_data), 64'h0000_0000_EDCB_A987);
    i_mode = 2'b00;
    send(32'hA5A5_A5A5, 1'b0);
    check("coh_b1", 64'(m_axis_data), 64'h0000_0000_5A5A_5A5A);
    send(32'h0F0F_0F0F, 1'b1);
    check("coh_b2", 64'(m_axis_data), 64'h0000_0000_F0F0_F0F0);
    send(32'h1122_3344, 1'b1);
    check("coh_next", 64'(m_axis_data), 64'h0000_0000_1122_3344);
    s_axis_valid = 1'b0;
    repeat (2) cycle();

    // Backpressure: only two beats absorbed, then async reset discards them.
    m_axis_ready = 1'b0;
    s_axis_valid = 1'b1;
    s_axis_last  = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      s_axis_data = 32'hC0DE_0000 + 32'(i);
      cycle();
      if (last_acc) acc_cnt++;
    end
    check("bp_absorbed", 64'(acc_cnt), 64'(2));
    check("bp_ready_low", 64'(s_axis_ready), 64'(0));
    #2;
    i_arst_n = 1'b0;
    #1;
    check("mid_rst_s_ready", 64'(s_axis_ready), 64'(0));
    check("mid_rst_m_valid", 64'(m_axis_valid), 64'(0));
    check("mid_rst_m_data",  64'(m_axis_data),  64'(0));
    check("mid_rst_m_last",  64'(m_axis_last),  64'(0));
    check("mid_rst_frames",  64'(o_frame_cnt),  64'(0));
    model_reset();
    s_axis_valid = 1'b0;
    m_axis_ready = 1'b1;
    #3;
    i_arst_n = 1'b1;
    cycle();
    cycle();
    check("no_stale_beat", 64'(m_axis_valid), 64'(0));

    // Frame counter wrap with single-beat frames at full rate.
    i_mode = 2'b00;
    s_axis_valid = 1'b1;
    s_axis_last  = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      s_axis_data = 32'(i);
      cycle();
    end
    s_axis_valid = 1'b0;
    cycle();
    check("frames_ffff", 64'(o_frame_cnt), 64'hFFFF);
    send(32'h5555_AAAA, 1'b1);
    s_axis_valid = 1'b0;
    cycle();
    check("frames_wrap", 64'(o_frame_cnt), 64'(0));

    // Random traffic with random backpressure and random config.
    beats = 0;
    last_acc = 1'b0;
    s_axis_valid = 1'b0;
    for (int cyc = 0; cyc < 20000 && beats < 1000; cyc++) begin
      if (!s_axis_valid || last_acc) begin
        s_axis_valid = ($urandom_range(0, 3) != 0);
        s_axis_data  = $urandom;
        s_axis_last  = ($urandom_range(0, 4) == 0);
      end
      i_mode       = 2'($urandom);
      i_offset     = 8'($urandom);
      i_thresh     = 8'($urandom);
      m_axis_ready = ($urandom_range(0, 9) < 7);
      cycle();
      if (last_acc) beats++;
    end
    check("random_beats", 64'(beats), 64'(1000));
    s_axis_valid = 1'b0;
    m_axis_ready = 1'b1;
    repeat (4) cycle();
    check("drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
